// File: rtl/usb_dev_responder.sv
// usb_dev_responder: device-side USB transaction engine answering OUT/IN tokens
// with handshakes or DATAx packets, buffering one payload per direction.
module usb_dev_responder #(
    parameter logic [6:0] DEV_ADDR = 7'd5,
    parameter logic [3:0] OUT_ENDP = 4'd4,
    parameter logic [3:0] IN_ENDP  = 4'd8,
    parameter int         TIMEOUT  = 255,
    parameter int         TW       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pktready,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic        rx_error,
    input  logic        tx_down_ready,
    output logic        tx_pktready,
    output logic [3:0]  tx_pid,
    output logic        tx_pkttype,
    output logic [63:0] tx_data,
    output logic        out_valid,
    output logic [63:0] out_data,
    input  logic        out_ack,
    input  logic        in_load,
    input  logic [63:0] in_wdata,
    output logic        in_full
);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_ACK, TX_WAIT} state_t;

    state_t        state, state_n, resp, resp_n;
    logic [TW-1:0] timer, timer_n;
    logic          out_tog, out_tog_n, in_tog, in_tog_n;
    logic          out_valid_n, in_full_n, tx_pkttype_n;
    logic [3:0]    tx_pid_n;
    logic [63:0]   out_data_n, in_buf, in_buf_n, tx_data_n;
    logic          is_data, is_token, for_us, timed_out;
    logic [3:0]    out_pid;

    assign is_data   = rx_pid == PID_DATA0 || rx_pid == PID_DATA1;
    assign is_token  = rx_pid == PID_OUT || rx_pid == PID_IN || rx_pid == PID_SETUP;
    assign for_us    = rx_pktready && !rx_error && rx_addr == DEV_ADDR;
    assign timed_out = timer == TW'(TIMEOUT);
    assign out_pid   = out_tog ? PID_DATA1 : PID_DATA0;

    always_comb begin
        state_n      = state;
        resp_n       = resp;
        timer_n      = timer;
        out_tog_n    = out_tog;
        in_tog_n     = in_tog;
        out_valid_n  = out_valid & ~out_ack;
        out_data_n   = out_data;
        in_full_n    = in_full;
        in_buf_n     = in_buf;
        tx_pid_n     = tx_pid;
        tx_pkttype_n = tx_pkttype;
        tx_data_n    = tx_data;
        tx_pktready  = 1'b0;
        // The IN buffer is frozen while a DATAx from it may be in flight.
        if (in_load && !in_full && (state == IDLE || state == WAIT_DATA)) begin
            in_buf_n  = in_wdata;
            in_full_n = 1'b1;
        end
        case (state)
            IDLE: begin
                if (for_us && rx_pid == PID_OUT && rx_endp == OUT_ENDP) begin
                    state_n = WAIT_DATA;
                    timer_n = '0;
                end else if (for_us && rx_pid == PID_IN && rx_endp == IN_ENDP) begin
                    state_n      = TX_WAIT;
                    resp_n       = in_full ? WAIT_ACK : IDLE;
                    tx_pid_n     = in_full ? (in_tog ? PID_DATA1 : PID_DATA0) : PID_NAK;
                    tx_pkttype_n = in_full;
                    tx_data_n    = in_full ? in_buf : '0;
                end else if (for_us && is_token) begin
                    state_n      = TX_WAIT;
                    resp_n       = IDLE;
                    tx_pid_n     = PID_STALL;
                    tx_pkttype_n = 1'b0;
                    tx_data_n    = '0;
                end
            end
            WAIT_DATA: begin
                timer_n = timer + 1'b1;
                if (rx_pktready) begin
                    state_n = IDLE;
                    if (is_data && !rx_error) begin
                        state_n      = TX_WAIT;
                        resp_n       = IDLE;
                        tx_pkttype_n = 1'b0;
                        tx_data_n    = '0;
                        // A toggle mismatch is a retry of data already taken: re-ACK it.
                        if (rx_pid != out_pid) begin
                            tx_pid_n = PID_ACK;
                        end else if (out_valid && !out_ack) begin
                            tx_pid_n = PID_NAK;
                        end else begin
                            tx_pid_n    = PID_ACK;
                            out_data_n  = rx_data;
                            out_valid_n = 1'b1;
                            out_tog_n   = ~out_tog;
                        end
                    end
                end else if (timed_out) begin
                    state_n = IDLE;
                end
            end
            WAIT_ACK: begin
                timer_n = timer + 1'b1;
                if (rx_pktready) begin
                    state_n = IDLE;
                    if (rx_pid == PID_ACK && !rx_error) begin
                        in_full_n = 1'b0;
                        in_tog_n  = ~in_tog;
                    end
                end else if (timed_out) begin
                    state_n = IDLE;
                end
            end
            TX_WAIT: begin
                timer_n = '0;
                if (tx_down_ready) begin
                    tx_pktready = 1'b1;
                    state_n     = resp;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp       <= IDLE;
            timer      <= '0;
            out_tog    <= 1'b0;
            in_tog     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            in_full    <= 1'b0;
            in_buf     <= '0;
            tx_pid     <= '0;
            tx_pkttype <= 1'b0;
            tx_data    <= '0;
        end else begin
            state      <= state_n;
            resp       <= resp_n;
            timer      <= timer_n;
            out_tog    <= out_tog_n;
            in_tog     <= in_tog_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            in_full    <= in_full_n;
            in_buf     <= in_buf_n;
            tx_pid     <= tx_pid_n;
            tx_pkttype <= tx_pkttype_n;
            tx_data    <= tx_data_n;
        end
    end
endmodule
